// File: rtl/line_buf_sched_pkg.sv
// Shared types, widths and index helper for the line buffer ring scheduler.
package line_buf_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        ACTIVE = 2'd2
    } rd_state_t;

    localparam int STAT_W = 16;

    // Next ring index: n-1 wraps back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        int unsigned res;
        if (idx == (n - 32'd1)) begin
            res = 32'd0;
        end else begin
            res = idx + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/line_buf_sched_stat_cnt.sv
// Saturating event counter used by the optional statistics outputs.
module line_buf_sched_stat_cnt
    import line_buf_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] count_r;

    // Count events, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {STAT_W{1'b0}};
        end else if (inc && (count_r != {STAT_W{1'b1}})) begin
            count_r <= count_r + {{(STAT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/line_buf_sched.sv
// Ring scheduler steering pixel lines into NUM_BUFS line buffers and replaying them in order.
// Define LINE_BUF_SCHED_STATS_EN to add lines_in_o / lines_out_o / drops_o counters.
module line_buf_sched
    import line_buf_sched_pkg::*;
#(
    parameter  int NUM_BUFS = 3,
    localparam int IDX_W    = $clog2(NUM_BUFS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic                line_end_i,
    input  logic [NUM_BUFS-1:0] buf_empty_i,
    input  logic [NUM_BUFS-1:0] buf_unread_i,
    input  logic [NUM_BUFS-1:0] buf_line_end_i,
    input  logic                out_ready_i,
    output logic [IDX_W-1:0]    wr_sel_o,
    output logic [NUM_BUFS-1:0] pop_line_o,
    output logic [IDX_W-1:0]    rd_sel_o,
    output logic                rd_busy_o,
    output logic                drop_o
`ifdef LINE_BUF_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]   lines_in_o,
    output logic [STAT_W-1:0]   lines_out_o,
    output logic [STAT_W-1:0]   drops_o
`endif
);

    logic [IDX_W-1:0]    wr_sel_r;
    logic [IDX_W-1:0]    rd_sel_r;
    logic [NUM_BUFS-1:0] pop_line_r;
    logic                rd_busy_r;
    logic                drop_r;
    logic                line_open_r;
    rd_state_t           state_r;

    logic [IDX_W-1:0]    wr_nxt_s;
    logic [IDX_W-1:0]    rd_nxt_s;
    logic [NUM_BUFS-1:0] pop_one_s;
    logic                line_done_s;
    logic                lap_s;
    logic                start_s;

    // Next pointers, lap detection and replay start qualification.
    always_comb begin
        wr_nxt_s    = IDX_W'(wrap_inc(32'(wr_sel_r), $unsigned(NUM_BUFS)));
        rd_nxt_s    = IDX_W'(wrap_inc(32'(rd_sel_r), $unsigned(NUM_BUFS)));
        pop_one_s   = {{(NUM_BUFS-1){1'b0}}, 1'b1} << rd_sel_r;
        line_done_s = push_i && line_end_i;
        // Conservative: uses the read pointer/busy state before this cycle's update.
        lap_s       = (wr_nxt_s == rd_sel_r) && (rd_busy_r || buf_unread_i[rd_sel_r]);
        // Never replay the buffer that a partially written line is still filling.
        start_s     = out_ready_i && buf_unread_i[rd_sel_r] && !buf_empty_i[rd_sel_r]
                      && !((wr_sel_r == rd_sel_r) && (line_open_r || push_i));
    end

    // Write pointer advance, drop pulse and open-line tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_sel_r    <= {IDX_W{1'b0}};
            drop_r      <= 1'b0;
            line_open_r <= 1'b0;
        end else begin
            if (line_done_s && !lap_s) begin
                wr_sel_r <= wr_nxt_s;
            end else begin
                wr_sel_r <= wr_sel_r;
            end
            drop_r <= line_done_s && lap_s;
            if (push_i) begin
                line_open_r <= !line_end_i;
            end else begin
                line_open_r <= line_open_r;
            end
        end
    end

    // Read FSM: one-cycle pop, then hold the buffer until its line end.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            rd_sel_r   <= {IDX_W{1'b0}};
            pop_line_r <= {NUM_BUFS{1'b0}};
            rd_busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r    <= POP;
                        pop_line_r <= pop_one_s;
                        rd_busy_r  <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        pop_line_r <= {NUM_BUFS{1'b0}};
                        rd_busy_r  <= 1'b0;
                    end
                end
                POP: begin
                    state_r    <= ACTIVE;
                    pop_line_r <= {NUM_BUFS{1'b0}};
                    rd_busy_r  <= 1'b1;
                end
                ACTIVE: begin
                    pop_line_r <= {NUM_BUFS{1'b0}};
                    if (buf_line_end_i[rd_sel_r]) begin
                        state_r   <= IDLE;
                        rd_sel_r  <= rd_nxt_s;
                        rd_busy_r <= 1'b0;
                    end else begin
                        state_r   <= ACTIVE;
                        rd_sel_r  <= rd_sel_r;
                        rd_busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    pop_line_r <= {NUM_BUFS{1'b0}};
                    rd_busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_sel_o   = wr_sel_r;
    assign rd_sel_o   = rd_sel_r;
    assign pop_line_o = pop_line_r;
    assign rd_busy_o  = rd_busy_r;
    assign drop_o     = drop_r;

`ifdef LINE_BUF_SCHED_STATS_EN
    line_buf_sched_stat_cnt u_lines_in (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (line_done_s),
        .count (lines_in_o)
    );

    line_buf_sched_stat_cnt u_lines_out (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (|pop_line_r),
        .count (lines_out_o)
    );

    line_buf_sched_stat_cnt u_drops (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (drop_r),
        .count (drops_o)
    );
`endif

endmodule
